// File: rtl/lift_pkg.sv
// lift_pkg: shared constants and encodings for the 5/3 lifting blocks.
// Holds the default sample width, the rounding constant of the update step,
// the sequencer state encoding and the predict/update phase encoding.
package lift_pkg;
    localparam int DW = 19;
    localparam int ROUND = 2;
    typedef enum logic [2:0] {IDLE, RD_L, RD_C, RD_R, CALC, WR, FIN} state_t;
    typedef enum logic {PH_PRED, PH_UPD} phase_t;
endpackage

// File: rtl/lift_alu.sv
// lift_alu: combinational 5/3 lifting step for one coefficient.
// Ports: l, c, r - left, centre and right samples (W-bit two's complement)
//        phase   - PH_PRED: c - ((l + r) >>> 1), PH_UPD: c + ((l + r + 2) >>> 2)
//        result  - new centre value, wrapped modulo 2^W
module lift_alu
    import lift_pkg::*;
#(
    parameter int W = DW
) (
    input  logic [W-1:0] l,
    input  logic [W-1:0] c,
    input  logic [W-1:0] r,
    input  phase_t       phase,
    output logic [W-1:0] result
);
    logic signed [W+1:0] sum;
    logic signed [W+1:0] step;

    // Two guard bits keep the neighbour sum plus rounding exact before the shift.
    always_comb begin
        sum = {{2{l[W-1]}}, l} + {{2{r[W-1]}}, r} + ((phase == PH_UPD) ? (W+2)'(ROUND) : '0);
        step = (phase == PH_UPD) ? (sum >>> 2) : (sum >>> 1);
        result = (phase == PH_UPD) ? c + step[W-1:0] : c - step[W-1:0];
    end
endmodule

// File: rtl/lift_seq.sv
// lift_seq: in-place 5/3 lifting of one row held in an external memory.
// Ports: clk, rst (async, active-high)
//        start, len         - request and row length (even, 4..2^AW)
//        busy, done, err    - status; err pulses with done for a rejected len
//        mem_addr, mem_rd, mem_rdata (one-cycle read latency)
//        mem_wr, mem_wdata  - row-memory write port
module lift_seq #(
    parameter int DW = lift_pkg::DW,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata
);
    import lift_pkg::*;

    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] TWO  = (AW+1)'(2);
    localparam logic [AW:0] LMIN = (AW+1)'(4);
    localparam logic [AW:0] LMAX = (AW+1)'(1 << AW);

    state_t        state;
    phase_t        ph;
    logic [AW:0]   idx;
    logic [AW:0]   len_q;
    logic [AW:0]   nxt;
    logic [AW:0]   rgt;
    logic [DW-1:0] l_q;
    logic [DW-1:0] c_q;
    logic [DW-1:0] result;
    logic          last;
    logic          ok;

    // Only the last odd index reaches past the row end, so only it mirrors to len-2.
    // Predict ends at len-1 and update at len-2; both give idx+1 >= len-1.
    always_comb begin
        nxt = idx + ONE;
        rgt = (nxt == len_q) ? len_q - TWO : nxt;
        last = nxt >= len_q - ONE;
        ok = !len[0] && len >= LMIN && len <= LMAX;
    end

    // The right neighbour arrives on mem_rdata during CALC, so it feeds the ALU directly.
    lift_alu #(.W(DW)) u_alu (
        .l      (l_q),
        .c      (c_q),
        .r      (mem_rdata),
        .phase  (ph),
        .result (result)
    );

    // Outputs are set on the edge that enters each state, so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ph <= PH_PRED;
            idx <= '0;
            len_q <= '0;
            l_q <= '0;
            c_q <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && ok) begin
                        state <= RD_L;
                        ph <= PH_PRED;
                        idx <= ONE;
                        len_q <= len;
                        busy <= 1'b1;
                        mem_rd <= 1'b1;
                        mem_addr <= '0;
                    end else if (start) begin
                        state <= FIN;
                        done <= 1'b1;
                        err <= 1'b1;
                    end
                end
                RD_L: begin
                    state <= RD_C;
                    mem_rd <= 1'b1;
                    mem_addr <= AW'(idx);
                end
                RD_C: begin
                    l_q <= mem_rdata;
                    state <= RD_R;
                    mem_rd <= 1'b1;
                    mem_addr <= AW'(rgt);
                end
                RD_R: begin
                    c_q <= mem_rdata;
                    state <= CALC;
                end
                CALC: begin
                    state <= WR;
                    mem_wr <= 1'b1;
                    mem_addr <= AW'(idx);
                    mem_wdata <= result;
                end
                WR: begin
                    if (last && ph == PH_UPD) begin
                        state <= FIN;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        // Update starts at x[0], whose left neighbour mirrors to x[1].
                        state <= RD_L;
                        mem_rd <= 1'b1;
                        mem_addr <= last ? AW'(1) : AW'(nxt);
                        ph <= last ? PH_UPD : ph;
                        idx <= last ? '0 : idx + TWO;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lift_seq.sv
// tb_lift_seq: randomized self-checking bench for lift_seq against a row-level lifting model.
module tb_lift_seq;
    localparam int DW = 19;
    localparam int AW = 9;
    localparam int NM = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;

    logic signed [DW-1:0] mem [0:NM-1];
    int  init [0:NM-1];
    logic load = 1'b0;
    int  row_q[$];
    int  exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;

    lift_seq #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NM; i++) mem[i] <= init[i][DW-1:0];
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int wrap(input int v);
        logic signed [DW-1:0] t;
        t = v[DW-1:0];
        return int'(t);
    endfunction

    function automatic void model(input int n);
        int l;
        int r;
        exp_q = row_q;
        for (int i = 1; i < n; i += 2) begin
            r = (i + 1 < n) ? exp_q[i+1] : exp_q[n-2];
            exp_q[i] = wrap(exp_q[i] - ((exp_q[i-1] + r) >>> 1));
        end
        for (int i = 0; i < n; i += 2) begin
            l = (i == 0) ? exp_q[1] : exp_q[i-1];
            exp_q[i] = wrap(exp_q[i] + ((l + exp_q[i+1] + 2) >>> 2));
        end
    endfunction

    task automatic load_mem(input int n);
        if (row_q.size() == 0)
            for (int i = 0; i < n; i++) row_q.push_back(wrap(int'($urandom)));
        for (int i = 0; i < NM; i++) init[i] = (i < row_q.size()) ? row_q[i] : i;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic run(input int n, input int s2);
        bit ok;
        int dcyc, dcnt, ecnt, rdn, wrn, both, bsy, busyd, budget;
        ok = (n % 2 == 0) && n >= 4 && n <= NM;
        if (!ok) row_q.delete();
        load_mem(ok ? n : 0);
        if (ok) model(n);
        dcyc = -1; dcnt = 0; ecnt = 0; rdn = 0; wrn = 0; both = 0; bsy = 0; busyd = -1;
        budget = ok ? 5 * n + 12 : 12;
        @(negedge clk);
        start = 1'b1;
        len = (AW+1)'(n);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                if (dcyc < 0) begin dcyc = c; busyd = int'(busy); end
            end
            if (err) ecnt++;
            if (busy) bsy++;
            if (mem_rd) rdn++;
            if (mem_wr) wrn++;
            if (mem_rd && mem_wr) both++;
            start = (c == s2) ? 1'b1 : 1'b0;
            if (c == s2) len = (AW+1)'(8);
        end
        chk($sformatf("done_cycle len=%0d", n), dcyc, ok ? 5 * n + 1 : 1);
        chk($sformatf("done_count len=%0d", n), dcnt, 1);
        chk($sformatf("err_count len=%0d", n), ecnt, ok ? 0 : 1);
        chk($sformatf("busy_cycles len=%0d", n), bsy, ok ? 5 * n : 0);
        chk($sformatf("busy_at_done len=%0d", n), busyd, 0);
        chk($sformatf("rd_count len=%0d", n), rdn, ok ? 3 * n : 0);
        chk($sformatf("wr_count len=%0d", n), wrn, ok ? n : 0);
        chk($sformatf("rd_wr_overlap len=%0d", n), both, 0);
        if (ok)
            for (int i = 0; i < n; i++) chk($sformatf("x[%0d] len=%0d", i, n), int'(mem[i]), exp_q[i]);
        row_q.delete();
    endtask

    task automatic want4(input int a, input int b, input int c, input int d);
        chk("row[0]", int'(mem[0]), a);
        chk("row[1]", int'(mem[1]), b);
        chk("row[2]", int'(mem[2]), c);
        chk("row[3]", int'(mem[3]), d);
    endtask

    task automatic rst_test();
        int dcnt = 0;
        load_mem(8);
        @(negedge clk);
        start = 1'b1;
        len = (AW+1)'(8);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dcnt++;
        end
        rst = 1'b1;
        #1 chk("rst_outputs", longint'({busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata}), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("rst_no_done", dcnt, 0);
        row_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", longint'({busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata}), 0);
        rst = 1'b0;
        row_q = '{164, 164, 164, 164};
        run(4, 0);
        want4(164, 0, 164, 0);
        row_q = '{156, 148, 112, 132};
        run(4, 0);
        want4(163, 14, 121, 20);
        row_q = '{0, -100, 0, 0};
        run(4, 0);
        want4(-50, -100, -25, 0);
        run(5, 0);
        run(2, 0);
        run(0, 0);
        run(514, 0);
        run(8, 7);
        rst_test();
        run(8, 0);
        run(NM, 0);
        repeat (10) run(2 * int'($urandom_range(2, 32)), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lift_seq.md
LIFT_SEQ -- requirements
Module: lift_seq

Interface
REQ-001 Parameter DW, default 19, sets the sample width (two's-complement signed).
REQ-002 Parameter AW, default 9, sets the row-memory address width.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port start, input, 1 bit: one-cycle request to transform one row.
REQ-006 Port len, input, AW+1 bits: row length in samples, sampled with start.
REQ-007 Port busy, output, 1 bit: a transform is in progress.
REQ-008 Port done, output, 1 bit: one-cycle completion pulse.
REQ-009 Port err, output, 1 bit: one-cycle pulse for a rejected len; coincides with done.
REQ-010 Port mem_addr, output, AW bits: row-memory address.
REQ-011 Port mem_rd, output, 1 bit: read strobe; mem_rdata is valid in the next cycle.
REQ-012 Port mem_rdata, input, DW bits: read data.
REQ-013 Port mem_wr, output, 1 bit: write strobe.
REQ-014 Port mem_wdata, output, DW bits: write data.

Function
REQ-015 The block shall perform the in-place 5/3 lifting of x[0..len-1]: first a predict pass, then an update pass.
REQ-016 Predict pass: for odd i, ascending, x[i] <= x[i] - ((x[i-1] + x[i+1]) >>> 1); x[len] is mirrored to x[len-2].
REQ-017 Update pass: for even i, ascending, x[i] <= x[i] + ((x[i-1] + x[i+1] + 2) >>> 2); x[-1] is mirrored to x[1].
REQ-018 Sums shall be computed at DW+2 bits; shifts are arithmetic; the result wraps modulo 2^DW.
REQ-019 Each coefficient shall use five states, in order:
- RD_L: mem_rd=1, address = left neighbour.
- RD_C: mem_rd=1, address = i.
- RD_R: mem_rd=1, address = right neighbour.
- CALC: no memory access; the result is registered.
- WR: mem_wr=1, mem_addr=i, mem_wdata=result.
REQ-020 FSM states: IDLE, RD_L, RD_C, RD_R, CALC, WR, FIN. An internal phase bit selects predict or update.
REQ-021 Transitions:
- IDLE->RD_L on an accepted start.
- WR->RD_L while coefficients remain.
- The last predict WR goes to update RD_L.
- The last update WR goes to FIN.
- FIN->IDLE unconditionally.
REQ-022 start is accepted only in IDLE with len even and 4 <= len <= 2^AW.
REQ-023 start in IDLE with an invalid len: next cycle done=1 and err=1; no memory access.
REQ-024 start while busy=1 shall be ignored.
REQ-025 busy=1 from the cycle after acceptance through the final WR; busy=0 in FIN.
REQ-026 done=1 only in FIN, exactly 5*len+1 cycles after the accepting edge.
REQ-027 mem_rd and mem_wr are never asserted together; both are 0 in IDLE and FIN.

Reset
REQ-028 rst shall force IDLE, clear the phase and indices, and drive busy, done, err, mem_rd, mem_wr, mem_addr and mem_wdata to 0.
REQ-029 rst mid-row aborts the transform without rollback; memory may be partially updated, and no done is issued.
REQ-030 After rst deasserts, the block shall accept start on the first clock edge.

Structure
REQ-031 A shared package lift_pkg shall hold DW, the state encoding, the phase encoding and the rounding constant 2.
REQ-032 The arithmetic shall be one combinational sub-module, lift_alu (inputs l, c, r, phase; output result), reusable by other lifting blocks.

Verification
REQ-033 len=4, row [164,164,164,164] -> final [164,0,164,0]; done 21 cycles after start.
REQ-034 len=4, row [156,148,112,132] -> final [163,14,121,20].
REQ-035 len=4, row [0,-100,0,0] -> final [-50,-100,-25,0] (checks arithmetic-shift rounding toward negative infinity).
REQ-036 len=5 and len=2 -> err=done=1 one cycle later; no mem_rd/mem_wr; busy stays 0.
REQ-037 Second start at cycle 7 of a len=8 run -> ignored; a single done at cycle 41.
REQ-038 rst at cycle 10 of a len=8 run -> all outputs 0 immediately; a new start afterwards completes correctly.
